// File: rtl/mem_arbiter2.sv
// rtl/mem_arbiter2.sv - two-master round-robin arbiter for the picorv32 native memory bus
// Grants are held until slave completion; an optional response timeout aborts hung transactions.
module mem_arbiter2 #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF,
  parameter int          CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err,
  output logic [31:0] err_addr
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_GNT0 = 2'b01;
  localparam logic [1:0] S_GNT1 = 2'b10;

  localparam logic [CNT_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]       r_state;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_err_addr;
  logic             r_timeout_err;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_granted;
  logic        w_cur_valid;
  logic        w_cur_instr;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_wdata;
  logic [3:0]  w_cur_wstrb;
  logic        w_done;
  logic        w_abort;
  logic        w_resp;
  logic [31:0] w_rdata;

  assign w_gnt0    = (r_state == S_GNT0);
  assign w_gnt1    = (r_state == S_GNT1);
  assign w_granted = w_gnt0 | w_gnt1;

  always_comb begin
    w_cur_valid = 1'b0;
    w_cur_instr = 1'b0;
    w_cur_addr  = '0;
    w_cur_wdata = '0;
    w_cur_wstrb = '0;
    if (w_gnt0) begin
      w_cur_valid = m0_valid;
      w_cur_instr = m0_instr;
      w_cur_addr  = m0_addr;
      w_cur_wdata = m0_wdata;
      w_cur_wstrb = m0_wstrb;
    end else if (w_gnt1) begin
      w_cur_valid = m1_valid;
      w_cur_instr = m1_instr;
      w_cur_addr  = m1_addr;
      w_cur_wdata = m1_wdata;
      w_cur_wstrb = m1_wstrb;
    end
  end

  // A slave completion in the would-be abort cycle takes priority over the timeout.
  assign w_done  = w_granted && s_ready;
  assign w_abort = (TIMEOUT_CYCLES > 0) && w_granted && (r_cnt == TMO_LAST) && !s_ready;
  assign w_resp  = w_done || w_abort;
  assign w_rdata = w_abort ? ERR_DATA : s_rdata;

  assign s_valid = w_cur_valid && !w_abort;
  assign s_instr = w_cur_instr;
  assign s_addr  = w_cur_addr;
  assign s_wdata = w_cur_wdata;
  assign s_wstrb = w_cur_wstrb;

  assign m0_ready = w_gnt0 && w_resp;
  assign m1_ready = w_gnt1 && w_resp;
  assign m0_rdata = w_gnt0 ? w_rdata : '0;
  assign m1_rdata = w_gnt1 ? w_rdata : '0;

  assign grant       = r_state;
  assign timeout_err = r_timeout_err;
  assign err_addr    = r_err_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b1;
      r_cnt         <= '0;
      r_err_addr    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_abort;
      if (w_abort) begin
        r_err_addr <= w_cur_addr;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (m0_valid && m1_valid) begin
            r_state <= r_last ? S_GNT0 : S_GNT1;
          end else if (m0_valid) begin
            r_state <= S_GNT0;
          end else if (m1_valid) begin
            r_state <= S_GNT1;
          end
        end
        S_GNT0, S_GNT1: begin
          if (w_resp) begin
            r_state <= S_IDLE;
            r_last  <= w_gnt1;
            r_cnt   <= '0;
          end else if (!w_cur_valid) begin
            // Master withdrew without a response: release the bus, fairness unchanged.
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb/tb_mem_arbiter2.sv - directed self-checking bench for mem_arbiter2
module tb_mem_arbiter2;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;
  logic [31:0] err_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter2 #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_BEEF), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err), .err_addr(err_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_s_valid got=%b exp=0", s_valid); end
    total++; if ({m0_ready, m1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {m0_ready, m1_ready}); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    total++; if (err_addr !== 32'h0) begin bad++; $display("FAIL reset_err_addr got=%h exp=0", err_addr); end
    total++; if (s_addr !== 32'h0 || m0_rdata !== 32'h0) begin bad++; $display("FAIL reset_idle_bus got=%h/%h exp=0/0", s_addr, m0_rdata); end
  endtask

  task automatic test_single_read();
    m0_valid = 1; m0_addr = 32'h4000_0010; m0_wstrb = 4'b0000; s_rdata = 32'hFFFF_0000;
    #1;
    total++; if (s_valid !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL rd_arb_cycle got=%b/%b exp=0/00", s_valid, grant); end
    tick();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL rd_grant got=%b exp=01", grant); end
    total++; if (s_valid !== 1'b1 || s_addr !== 32'h4000_0010) begin bad++; $display("FAIL rd_fwd got=%b/%h exp=1/40000010", s_valid, s_addr); end
    total++; if (m0_ready !== 1'b0) begin bad++; $display("FAIL rd_early_ready got=%b exp=0", m0_ready); end
    tick();
    s_ready = 1; s_rdata = 32'h1234_5678;
    #1;
    total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_resp got=%b/%h exp=1/12345678", m0_ready, m0_rdata); end
    total++; if (m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL rd_other got=%b/%h exp=0/0", m1_ready, m1_rdata); end
    tick();
    m0_valid = 0; s_ready = 0;
    #1;
    total++; if (grant !== 2'b00 || s_valid !== 1'b0) begin bad++; $display("FAIL rd_release got=%b/%b exp=00/0", grant, s_valid); end
  endtask

  task automatic test_write_m1();
    m1_valid = 1; m1_instr = 1; m1_addr = 32'h4000_0100; m1_wdata = 32'hA5A5_00FF; m1_wstrb = 4'b0011;
    tick();
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL wr_grant got=%b exp=10", grant); end
    total++; if (s_addr !== 32'h4000_0100 || s_wdata !== 32'hA5A5_00FF) begin bad++; $display("FAIL wr_fwd got=%h/%h exp=40000100/a5a500ff", s_addr, s_wdata); end
    total++; if (s_wstrb !== 4'b0011 || s_instr !== 1'b1) begin bad++; $display("FAIL wr_strb got=%b/%b exp=0011/1", s_wstrb, s_instr); end
    tick();
    s_ready = 1;
    #1;
    total++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin bad++; $display("FAIL wr_ready got=%b/%b exp=1/0", m1_ready, m0_ready); end
    tick();
    m1_valid = 0; m1_instr = 0; s_ready = 0;
    #1;
  endtask

  task automatic test_round_robin();
    int rem0;
    int rem1;
    int done_cnt;
    logic [1:0] exp_g;
    do_reset();
    rem0 = 4; rem1 = 4; done_cnt = 0;
    m0_valid = 1; m0_addr = 32'h0000_1000; m1_valid = 1; m1_addr = 32'h0000_2000;
    for (int k = 0; k < 8; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      total++; if (grant !== 2'b00) begin bad++; $display("FAIL rr_idle k=%0d got=%b exp=00", k, grant); end
      tick();
      total++; if (grant !== exp_g) begin bad++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, grant, exp_g); end
      tick();
      s_ready = 1; s_rdata = 32'hC000_0000 + k;
      #1;
      if (m0_ready === 1'b1) done_cnt++;
      if (m1_ready === 1'b1) done_cnt++;
      total++;
      if ({m1_ready, m0_ready} !== exp_g || (m0_rdata | m1_rdata) !== 32'hC000_0000 + k) begin
        bad++; $display("FAIL rr_resp k=%0d got=%b/%h exp=%b/%h", k, {m1_ready, m0_ready}, m0_rdata | m1_rdata, exp_g, 32'hC000_0000 + k);
      end
      tick();
      s_ready = 0;
      if (exp_g == 2'b01) begin rem0--; m0_valid = (rem0 > 0); end
      else begin rem1--; m1_valid = (rem1 > 0); end
    end
    total++; if (done_cnt !== 8) begin bad++; $display("FAIL rr_count got=%0d exp=8", done_cnt); end
    clear_inputs();
    #1;
  endtask

  task automatic test_timeout();
    m0_valid = 1; m0_addr = 32'h8000_0200; s_rdata = 32'h1111_2222;
    tick();
    for (int i = 1; i < 8; i++) begin
      total++; if (s_valid !== 1'b1 || m0_ready !== 1'b0) begin bad++; $display("FAIL to_wait c=%0d got=%b/%b exp=1/0", i, s_valid, m0_ready); end
      tick();
    end
    total++; if (s_valid !== 1'b0 || grant !== 2'b01) begin bad++; $display("FAIL to_abort_bus got=%b/%b exp=0/01", s_valid, grant); end
    total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_abort_resp got=%b/%h exp=1/deadbeef", m0_ready, m0_rdata); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_early_pulse got=%b exp=0", timeout_err); end
    tick();
    m0_valid = 0; m1_valid = 1; m1_addr = 32'h0000_3000;
    #1;
    total++; if (timeout_err !== 1'b1 || err_addr !== 32'h8000_0200) begin bad++; $display("FAIL to_pulse got=%b/%h exp=1/80000200", timeout_err, err_addr); end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL to_idle got=%b exp=00", grant); end
    tick();
    total++; if (grant !== 2'b10 || timeout_err !== 1'b0) begin bad++; $display("FAIL to_next_grant got=%b/%b exp=10/0", grant, timeout_err); end
    s_ready = 1; s_rdata = 32'h0BAD_F00D;
    #1;
    total++; if (m1_ready !== 1'b1 || m1_rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL to_next_resp got=%b/%h exp=1/0badf00d", m1_ready, m1_rdata); end
    tick();
    clear_inputs();
    #1;
  endtask

  task automatic test_coincide();
    m0_valid = 1; m0_addr = 32'h8000_0300;
    tick();
    for (int i = 1; i < 8; i++) tick();
    s_ready = 1; s_rdata = 32'hCAFE_F00D;
    #1;
    total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL co_resp got=%b/%h exp=1/cafef00d", m0_ready, m0_rdata); end
    total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL co_s_valid got=%b exp=1", s_valid); end
    tick();
    clear_inputs();
    #1;
    total++; if (timeout_err !== 1'b0 || err_addr !== 32'h8000_0200) begin bad++; $display("FAIL co_no_err got=%b/%h exp=0/80000200", timeout_err, err_addr); end
  endtask

  task automatic test_reset_mid();
    m1_valid = 1; m1_addr = 32'h0000_4000;
    tick();
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL rm_grant got=%b exp=10", grant); end
    reset = 1; m0_valid = 1; m0_addr = 32'h0000_5000;
    tick();
    reset = 0;
    #1;
    total++; if (grant !== 2'b00 || s_valid !== 1'b0) begin bad++; $display("FAIL rm_after got=%b/%b exp=00/0", grant, s_valid); end
    total++; if ({m1_ready, m0_ready} !== 2'b00) begin bad++; $display("FAIL rm_ready got=%b exp=00", {m1_ready, m0_ready}); end
    tick();
    total++; if (grant !== 2'b01 || s_addr !== 32'h0000_5000) begin bad++; $display("FAIL rm_m0_first got=%b/%h exp=01/00005000", grant, s_addr); end
    s_ready = 1;
    #1;
    total++; if (m0_ready !== 1'b1) begin bad++; $display("FAIL rm_m0_done got=%b exp=1", m0_ready); end
    tick();
    m0_valid = 0; s_ready = 0;
    tick();
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL rm_m1_next got=%b exp=10", grant); end
    clear_inputs();
    tick();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_m1();
    test_round_robin();
    test_timeout();
    test_coincide();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
- Two-master, one-slave arbiter for the picorv32 native memory interface (valid/instr/ready/addr/wdata/wstrb/rdata).
- Shares one memory or peripheral port between two requesters, e.g. the CPU core and a DMA/debug master, in front of the main RAM model or the APB/AHB bridge.
- Round-robin fairness. Each grant is held until the slave completes the transaction.
- An optional response timeout completes hung transactions with an error word.

Parameters:
- TIMEOUT_CYCLES, 256: cycles in a grant state without s_ready before abort; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned to the master on a timeout abort.
- CNT_W, 16: timeout counter width; TIMEOUT_CYCLES must be < 2**CNT_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_valid/m1_valid  in  1  master request, held until the matching ready.
- m0_instr/m1_instr  in  1  instruction-fetch qualifier.
- m0_addr/m1_addr  in  32  byte address.
- m0_wdata/m1_wdata  in  32  write data.
- m0_wstrb/m1_wstrb  in  4  byte strobes; 0 = read.
- m0_ready/m1_ready  out  1  transaction complete, one cycle.
- m0_rdata/m1_rdata  out  32  read data, valid with ready.
- s_valid  out  1  request to the slave.
- s_instr  out  1  forwarded instr.
- s_addr  out  32  forwarded addr.
- s_wdata  out  32  forwarded wdata.
- s_wstrb  out  4  forwarded wstrb.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- grant  out  2  one-hot current owner {m1,m0}; 00 = idle.
- timeout_err  out  1  one-cycle pulse on abort.
- err_addr  out  32  address of the last aborted transaction, sticky.

Behaviour:
- States: IDLE, GNT0, GNT1. The state register, last-owner bit `last`, timeout counter, err_addr and timeout_err are registered. All s_* and m*_ready/rdata are combinational from state.
- Reset (clk edge with reset=1, including mid-transaction):
  - state=IDLE, last=1 so m0 wins the first tie, counter=0, err_addr=0, timeout_err=0.
  - Consequently s_valid=0, m*_ready=0, m*_rdata=0, grant=00.
  - An in-flight transaction is dropped with no ready to either master.
- IDLE:
  - s_valid=0; s_addr/wdata/wstrb/instr=0.
  - Only m0_valid → GNT0. Only m1_valid → GNT1.
  - Both valid → GNT1 if last==0, else GNT0.
  - Arbitration costs exactly one cycle: a request seen in IDLE at edge T is driven to the slave from T+1.
- GNTx:
  - s_* = mx_* pass-through; s_valid = mx_valid.
  - mx_ready = s_ready; mx_rdata = s_rdata. The other master sees ready=0, rdata=0.
  - s_ready=1 → next IDLE, last=x, counter=0.
  - mx_valid deasserted without ready (protocol violation) → next IDLE, last unchanged, no ready.
  - Otherwise counter increments each cycle.
- Minimum occupancy: 1 arbitration cycle + slave latency. A one-cycle-latency slave gives 3 cycles request-to-ready, then 1 idle cycle before the next grant.
- Timeout (TIMEOUT_CYCLES>0): in GNTx with counter==TIMEOUT_CYCLES-1 and s_ready=0, this is the abort cycle:
  - s_valid forced 0.
  - mx_ready=1, mx_rdata=ERR_DATA.
  - Write aborts also return ready; the write is lost.
  - err_addr<=mx_addr; timeout_err pulses the following cycle.
  - Next IDLE, last=x.
  - If s_ready and the timeout coincide, s_ready wins: normal completion, no error.
  - The slave must tolerate valid withdrawal. A late s_ready while IDLE is ignored.
- Counter never wraps: it is cleared on every transition into IDLE and compared with ==.
- While one master is granted, the other's valid is ignored; it is served next because of round-robin, so maximum wait is one transaction plus one cycle.
- grant is registered state decode, never 11.

Test Plan:
- Single m0 read of addr 32'h4000_0010, slave returns 32'h1234_5678 one cycle after s_valid → grant=01 at T+1, m0_ready=1 with m0_rdata=32'h1234_5678 at T+2 (1-cycle slave), grant=00 at T+3, m1_ready stays 0.
- m0 and m1 both valid from reset release, each issuing 4 back-to-back reads → grants strictly alternate 01,10,01,10… starting with m0; 8 completions total, no starvation.
- m1 write addr 32'h4000_0100, wdata 32'hA5A5_00FF, wstrb 4'b0011 → slave sees identical addr/wdata/wstrb, s_instr=m1_instr; m0_ready never asserts.
- TIMEOUT_CYCLES=8, slave never asserts ready for m0 read of 32'h8000_0200 → m0_ready with rdata 32'hDEAD_BEEF in the 8th grant cycle, s_valid=0 that cycle, timeout_err pulse next cycle, err_addr=32'h8000_0200; the next m1 request is then served normally.
- s_ready asserted exactly in the would-be timeout cycle → normal completion with s_rdata, timeout_err stays 0.
- reset=1 for one cycle while in GNT1 awaiting s_ready → next cycle grant=00, s_valid=0, no ready to m1; a pending m0 and m1 pair then resolves to m0 first.
